// File: rtl/sdram_csr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_csr_pkg
// Brief    : Shared register offsets, FSM state encoding and STATUS bit
//            positions for the SDRAM CSR responder.
// Revision : 1.0 - initial release
// ============================================================================
package sdram_csr_pkg;

    // Register offsets within the CSR bank
    localparam logic [8:0] REG_STATUS = 9'd0;
    localparam logic [8:0] REG_ADDR0  = 9'd1;
    localparam logic [8:0] REG_ADDR1  = 9'd2;
    localparam logic [8:0] REG_ADDR2  = 9'd3;
    localparam logic [8:0] REG_ADDR3  = 9'd4;
    localparam logic [8:0] REG_DATA0  = 9'd5;
    localparam logic [8:0] REG_DATA1  = 9'd6;
    localparam logic [8:0] REG_DATA2  = 9'd7;
    localparam logic [8:0] REG_DATA3  = 9'd8;
    localparam logic [8:0] REG_INDEX  = 9'd9;
    localparam logic [8:0] REG_LEN    = 9'd10;
    localparam logic [8:0] REG_START  = 9'd11;
    localparam logic [8:0] REG_CNT_LO = 9'd12;
    localparam logic [8:0] REG_CNT_HI = 9'd13;

    // Transfer FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_t;

    // STATUS register bit positions
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

endpackage
`default_nettype wire

// File: rtl/sdram_csr_buf.sv
`default_nettype none
// ============================================================================
// Module   : sdram_csr_buf
// Brief    : BUF_DEPTH x 32-bit staging buffer. CSR side writes whole words
//            and reads combinationally; controller side reads
//            combinationally and writes returned SDRAM data.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_csr_buf #(
    parameter int BUF_DEPTH = 8
) (
    input  logic        clk,
    input  logic        i_csr_we,
    input  logic [2:0]  i_csr_idx,
    input  logic [31:0] i_csr_wdata,
    output logic [31:0] o_csr_rdata,
    input  logic [2:0]  i_ctl_idx,
    output logic [31:0] o_ctl_rdata,
    input  logic        i_ctl_we,
    input  logic [31:0] i_ctl_wdata
);

    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    // Contents are undefined after reset, so the array has no reset
    logic [31:0] mem_q [BUF_DEPTH];

    logic [AW-1:0] w_csr_a;
    logic [AW-1:0] w_ctl_a;

    assign w_csr_a = i_csr_idx[AW-1:0];
    assign w_ctl_a = i_ctl_idx[AW-1:0];

    // Word write; both ports are never active together because CSR writes
    // are blocked while a transfer is in flight
    always_ff @(posedge clk) begin
        if (i_ctl_we) begin
            mem_q[w_ctl_a] <= i_ctl_wdata;
        end else if (i_csr_we) begin
            mem_q[w_csr_a] <= i_csr_wdata;
        end
    end

    assign o_csr_rdata = mem_q[w_csr_a];
    assign o_ctl_rdata = mem_q[w_ctl_a];

endmodule
`default_nettype wire

// File: rtl/sdram_csr_slave.sv
`default_nettype none
// ============================================================================
// Module   : sdram_csr_slave
// Brief    : Byte-wide CSR responder for the SDRAM peripheral. Holds address,
//            length, direction and a staging buffer, and runs one
//            request/acknowledge transaction per START write.
//            Optional transfer counter: define SDRAM_CSR_XFER_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_csr_slave
    import sdram_csr_pkg::*;
#(
    parameter logic [4:0] CSR_BANK  = 5'd1,
    parameter int         BUF_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] adr,
    input  logic        we,
    input  logic [7:0]  dat_w,
    output logic [7:0]  dat_r,
    output logic        app_req,
    input  logic        app_req_ack,
    output logic        app_wr,
    output logic [31:0] app_addr,
    output logic [3:0]  app_len,
    input  logic        app_done,
    input  logic [2:0]  buf_idx,
    output logic [31:0] buf_rdata,
    input  logic        buf_we,
    input  logic [31:0] buf_wdata,
    output logic [1:0]  p_state
);

    localparam logic [4:0] LEN_MAX = 5'(BUF_DEPTH);

    state_t      state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [23:0] stage_q, stage_d;
    logic [2:0]  index_q, index_d;
    logic [3:0]  len_q,   len_d;
    logic        wr_q,    wr_d;
    logic        done_q,  done_d;
    logic        err_q,   err_d;
    logic [7:0]  dat_r_q, dat_r_d;

    logic        w_sel;
    logic        w_wr;
    logic        w_wr_cfg;
    logic        w_start;
    logic        w_busy;
    logic        w_xfer_done;
    logic        w_csr_buf_we;
    logic [31:0] w_csr_buf_wdata;
    logic [31:0] w_csr_buf_rdata;
    logic        w_ctl_buf_we;

    assign w_sel       = (adr[13:9] == CSR_BANK);
    assign w_wr        = we && w_sel;
    assign w_busy      = (state_q != IDLE);
    assign w_wr_cfg    = w_wr && !w_busy;
    assign w_xfer_done = (state_q == XFER) && app_done;
    // Controller may only fill the buffer during an SDRAM->buffer transfer
    assign w_ctl_buf_we = buf_we && (state_q == XFER) && !wr_q;

    // Configuration register writes, blocked while a transfer is active
    always_comb begin
        addr_d          = addr_q;
        stage_d         = stage_q;
        index_d         = index_q;
        len_d           = len_q;
        w_start         = 1'b0;
        w_csr_buf_we    = 1'b0;
        w_csr_buf_wdata = {dat_w, stage_q};
        if (w_wr_cfg) begin
            case (adr[8:0])
                REG_ADDR0: addr_d[7:0]    = dat_w;
                REG_ADDR1: addr_d[15:8]   = dat_w;
                REG_ADDR2: addr_d[23:16]  = dat_w;
                REG_ADDR3: addr_d[31:24]  = dat_w;
                REG_DATA0: stage_d[7:0]   = dat_w;
                REG_DATA1: stage_d[15:8]  = dat_w;
                REG_DATA2: stage_d[23:16] = dat_w;
                REG_DATA3: w_csr_buf_we   = 1'b1;
                REG_INDEX: index_d        = dat_w[2:0];
                REG_LEN:   len_d          = dat_w[3:0];
                REG_START: w_start        = 1'b1;
                default:   ;
            endcase
        end
    end

    // Transfer FSM: next state, sticky done/err and direction latch
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (w_start) begin
                    if (len_q == 4'd0 || {1'b0, len_q} > LEN_MAX) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        done_d  = 1'b0;
                        wr_d    = ~dat_w[0];
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (app_req_ack) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (app_done) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SDRAM_CSR_XFER_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Completed-transfer counter; a write to the low byte clears it
    always_comb begin
        cnt_d = cnt_q;
        if (w_wr && adr[8:0] == REG_CNT_LO) begin
            cnt_d = 16'd0;
        end else if (w_xfer_done && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Read data mux; unmapped or other-bank offsets return zero
    always_comb begin
        dat_r_d = 8'd0;
        if (w_sel) begin
            case (adr[8:0])
                REG_STATUS: begin
                    dat_r_d[STAT_BUSY] = w_busy;
                    dat_r_d[STAT_DONE] = done_q;
                    dat_r_d[STAT_ERR]  = err_q;
                end
                REG_ADDR0:  dat_r_d = addr_q[7:0];
                REG_ADDR1:  dat_r_d = addr_q[15:8];
                REG_ADDR2:  dat_r_d = addr_q[23:16];
                REG_ADDR3:  dat_r_d = addr_q[31:24];
                REG_DATA0:  dat_r_d = w_csr_buf_rdata[7:0];
                REG_DATA1:  dat_r_d = w_csr_buf_rdata[15:8];
                REG_DATA2:  dat_r_d = w_csr_buf_rdata[23:16];
                REG_DATA3:  dat_r_d = w_csr_buf_rdata[31:24];
                REG_INDEX:  dat_r_d = {5'd0, index_q};
                REG_LEN:    dat_r_d = {4'd0, len_q};
`ifdef SDRAM_CSR_XFER_COUNT_EN
                REG_CNT_LO: dat_r_d = cnt_q[7:0];
                REG_CNT_HI: dat_r_d = cnt_q[15:8];
`endif
                default:    dat_r_d = 8'd0;
            endcase
        end
    end

    // State and register file update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            stage_q <= 24'd0;
            index_q <= 3'd0;
            len_q   <= 4'd0;
            wr_q    <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dat_r_q <= 8'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            stage_q <= stage_d;
            index_q <= index_d;
            len_q   <= len_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            dat_r_q <= dat_r_d;
        end
    end

    sdram_csr_buf #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk         (clk),
        .i_csr_we    (w_csr_buf_we),
        .i_csr_idx   (index_q),
        .i_csr_wdata (w_csr_buf_wdata),
        .o_csr_rdata (w_csr_buf_rdata),
        .i_ctl_idx   (buf_idx),
        .o_ctl_rdata (buf_rdata),
        .i_ctl_we    (w_ctl_buf_we),
        .i_ctl_wdata (buf_wdata)
    );

    // Address/length only change in IDLE, so they are stable for the request
    assign dat_r    = dat_r_q;
    assign app_req  = (state_q == REQ);
    assign app_wr   = wr_q;
    assign app_addr = addr_q;
    assign app_len  = len_q;
    assign p_state  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_csr_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_csr_slave
// Brief    : Directed self-checking bench for sdram_csr_slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_csr_slave;

    localparam logic [4:0] BANK = 5'd1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] adr;
    logic        we;
    logic [7:0]  dat_w;
    logic [7:0]  dat_r;
    logic        app_req;
    logic        app_req_ack;
    logic        app_wr;
    logic [31:0] app_addr;
    logic [3:0]  app_len;
    logic        app_done;
    logic [2:0]  buf_idx;
    logic [31:0] buf_rdata;
    logic        buf_we;
    logic [31:0] buf_wdata;
    logic [1:0]  p_state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sdram_csr_slave #(
        .CSR_BANK  (BANK),
        .BUF_DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .adr         (adr),
        .we          (we),
        .dat_w       (dat_w),
        .dat_r       (dat_r),
        .app_req     (app_req),
        .app_req_ack (app_req_ack),
        .app_wr      (app_wr),
        .app_addr    (app_addr),
        .app_len     (app_len),
        .app_done    (app_done),
        .buf_idx     (buf_idx),
        .buf_rdata   (buf_rdata),
        .buf_we      (buf_we),
        .buf_wdata   (buf_wdata),
        .p_state     (p_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic csr_write(input logic [4:0] bank, input logic [8:0] off, input logic [7:0] d);
        adr   = {bank, off};
        we    = 1'b1;
        dat_w = d;
        tick();
        we    = 1'b0;
    endtask

    task automatic csr_read(input logic [4:0] bank, input logic [8:0] off, output logic [7:0] d);
        adr = {bank, off};
        we  = 1'b0;
        tick();
        d   = dat_r;
    endtask

    task automatic check_reg(input string tag, input logic [8:0] off, input logic [7:0] exp);
        logic [7:0] v;
        csr_read(BANK, off, v);
        check(tag, {24'd0, v}, {24'd0, exp});
    endtask

    initial begin
        logic [7:0] cnt_exp;
        rst_n       = 1'b0;
        adr         = '0;
        we          = 1'b0;
        dat_w       = '0;
        app_req_ack = 1'b0;
        app_done    = 1'b0;
        buf_idx     = 3'd0;
        buf_we      = 1'b0;
        buf_wdata   = '0;
        repeat (3) tick();

        // Reset values
        check("rst_app_req",  {31'd0, app_req}, 32'd0);
        check("rst_app_wr",   {31'd0, app_wr},  32'd1);
        check("rst_app_addr", app_addr,         32'd0);
        check("rst_app_len",  {28'd0, app_len}, 32'd0);
        check("rst_p_state",  {30'd0, p_state}, 32'd0);
        check("rst_dat_r",    {24'd0, dat_r},   32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            check_reg($sformatf("rst_reg%0d", i), 9'(i), 8'h00);
        end

        // Program a write transfer
        csr_write(BANK, 9'd1, 8'h01);
        csr_write(BANK, 9'd2, 8'h00);
        csr_write(BANK, 9'd3, 8'h00);
        csr_write(BANK, 9'd4, 8'h00);
        csr_write(BANK, 9'd9, 8'hFA);      // upper bits dropped -> 2
        csr_write(BANK, 9'd5, 8'h22);
        csr_write(BANK, 9'd6, 8'h11);
        csr_write(BANK, 9'd7, 8'h00);
        csr_write(BANK, 9'd8, 8'h00);
        csr_write(BANK, 9'd10, 8'h08);
        check_reg("addr0_rb", 9'd1, 8'h01);
        check_reg("index_rb", 9'd9, 8'h02);
        check_reg("len_rb",   9'd10, 8'h08);
        check_reg("data0_rb", 9'd5, 8'h22);
        check_reg("data1_rb", 9'd6, 8'h11);

        csr_write(BANK, 9'd11, 8'h00);
        check("wr_app_req",  {31'd0, app_req}, 32'd1);
        check("wr_app_wr",   {31'd0, app_wr},  32'd1);
        check("wr_app_len",  {28'd0, app_len}, 32'd8);
        check("wr_app_addr", app_addr,         32'd1);
        check("wr_p_state",  {30'd0, p_state}, 32'd1);
        buf_idx = 3'd2;
        #1;
        check("wr_buf_rdata", buf_rdata, 32'h0000_1122);
        check_reg("wr_status_busy", 9'd0, 8'h01);

        // Blocked config write while busy
        csr_write(BANK, 9'd10, 8'h03);
        tick();
        app_req_ack = 1'b1;
        tick();
        app_req_ack = 1'b0;
        check("wr_req_drop",  {31'd0, app_req}, 32'd0);
        check("wr_p_xfer",    {30'd0, p_state}, 32'd2);

        // Controller write ignored in a buffer->SDRAM transfer
        buf_we    = 1'b1;
        buf_wdata = 32'hDEAD_BEEF;
        tick();
        buf_we    = 1'b0;
        check("wr_buf_we_ign", buf_rdata, 32'h0000_1122);

        app_done = 1'b1;
        tick();
        app_done = 1'b0;
        check_reg("wr_status_done", 9'd0, 8'h02);
        check_reg("len_kept",       9'd10, 8'h08);
        check("idle_p_state", {30'd0, p_state}, 32'd0);

        // LEN == 0 rejected
        csr_write(BANK, 9'd10, 8'h00);
        csr_write(BANK, 9'd11, 8'h00);
        check("len0_no_req", {31'd0, app_req}, 32'd0);
        check_reg("len0_status", 9'd0, 8'h06);

        // Read transfer: controller fills buffer index 4
        csr_write(BANK, 9'd10, 8'h04);
        csr_write(BANK, 9'd11, 8'h01);
        check("rd_app_req", {31'd0, app_req}, 32'd1);
        check("rd_app_wr",  {31'd0, app_wr},  32'd0);
        check_reg("rd_status_busy", 9'd0, 8'h01);
        app_req_ack = 1'b1;
        tick();
        app_req_ack = 1'b0;
        buf_idx   = 3'd4;
        buf_we    = 1'b1;
        buf_wdata = 32'h5566_AABB;
        tick();
        buf_we    = 1'b0;
        check("rd_buf_rdata", buf_rdata, 32'h5566_AABB);
        app_done = 1'b1;
        tick();
        app_done = 1'b0;
        check_reg("rd_status_done", 9'd0, 8'h02);
        csr_write(BANK, 9'd9, 8'h04);
        check_reg("rd_data0", 9'd5, 8'hBB);
        check_reg("rd_data1", 9'd6, 8'hAA);
        check_reg("rd_data2", 9'd7, 8'h66);
        check_reg("rd_data3", 9'd8, 8'h55);

`ifdef SDRAM_CSR_XFER_COUNT_EN
        cnt_exp = 8'd2;
`else
        cnt_exp = 8'd0;
`endif
        check_reg("cnt_lo", 9'd12, cnt_exp);
        check_reg("cnt_hi", 9'd13, 8'h00);
        csr_write(BANK, 9'd12, 8'h5A);
        check_reg("cnt_clr", 9'd12, 8'h00);

        // LEN above buffer depth rejected
        csr_write(BANK, 9'd10, 8'h09);
        csr_write(BANK, 9'd11, 8'h00);
        check("len9_no_req", {31'd0, app_req}, 32'd0);
        check_reg("len9_status", 9'd0, 8'h06);

        // Other bank and unmapped offsets
        csr_write(5'd2, 9'd1, 8'hFF);
        check_reg("bank_ign_addr0", 9'd1, 8'h01);
        begin
            logic [7:0] v;
            csr_read(5'd2, 9'd1, v);
            check("other_bank_rd", {24'd0, v}, 32'd0);
        end
        csr_write(BANK, 9'd20, 8'hFF);
        check_reg("unmapped_rd", 9'd20, 8'h00);

        // Reset in the middle of a transfer
        csr_write(BANK, 9'd10, 8'h02);
        csr_write(BANK, 9'd11, 8'h00);
        app_req_ack = 1'b1;
        tick();
        app_req_ack = 1'b0;
        check("mid_p_xfer", {30'd0, p_state}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_app_req", {31'd0, app_req}, 32'd0);
        check("arst_p_state", {30'd0, p_state}, 32'd0);
        check("arst_dat_r",   {24'd0, dat_r},   32'd0);
        check("arst_app_wr",  {31'd0, app_wr},  32'd1);
        tick();
        rst_n = 1'b1;
        check_reg("arst_status", 9'd0, 8'h00);
        check_reg("arst_len",    9'd10, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
